// File: rtl/lif_spike_array.sv
// Multi-channel leaky integrate-and-fire spike generator with shift leak, saturating
// integration, refractory hold and a valid/ready result stage.
module lif_spike_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int SUB_RESET  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_CH*W-1:0]   cur_in,
    input  logic [W-1:0]        threshold,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_CH-1:0]     spk_out,
    output logic [N_CH*W-1:0]   v_out
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    // Clamp a W+2-bit intermediate to the signed W-bit range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] x);
        logic signed [W+1:0] max_v;
        logic signed [W+1:0] min_v;
        max_v = $signed({{3{1'b0}}, {(W-1){1'b1}}});
        min_v = $signed({{3{1'b1}}, {(W-1){1'b0}}});
        if (x > max_v) begin
            sat_w = max_v[W-1:0];
        end else if (x < min_v) begin
            sat_w = min_v[W-1:0];
        end else begin
            sat_w = x[W-1:0];
        end
    endfunction

    // Sign-extend a W-bit value into the W+2-bit working width.
    function automatic logic signed [W+1:0] ext(input logic [W-1:0] x);
        ext = $signed({{2{x[W-1]}}, x});
    endfunction

    logic [N_CH-1:0][W-1:0]  v_r;
    logic [N_CH-1:0][RW-1:0] refrac_r;

    logic [N_CH-1:0][W-1:0]  v_upd_s;
    logic [N_CH-1:0][RW-1:0] refrac_upd_s;
    logic [N_CH-1:0][W-1:0]  v_nxt_s;
    logic [N_CH-1:0][W-1:0]  leak_s;
    logic [N_CH-1:0]         spk_s;
    logic                    accept_s;

    assign in_ready = !out_valid || out_ready;
    assign accept_s = in_valid && in_ready;

    // Per-channel leak, integrate, fire and refractory update for the next timestep.
    always_comb begin
        v_upd_s      = v_r;
        refrac_upd_s = refrac_r;
        v_nxt_s      = v_r;
        leak_s       = v_r;
        spk_s        = {N_CH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            leak_s[c]  = $signed(v_r[c]) >>> LEAK_SHIFT;
            v_nxt_s[c] = sat_w(ext(v_r[c]) - ext(leak_s[c]) + ext(cur_in[c*W +: W]));
            if (refrac_r[c] != {RW{1'b0}}) begin
                refrac_upd_s[c] = refrac_r[c] - {{(RW-1){1'b0}}, 1'b1};
                v_upd_s[c]      = v_r[c];
                spk_s[c]        = 1'b0;
            end else if ($signed(v_nxt_s[c]) >= $signed(threshold)) begin
                spk_s[c]        = 1'b1;
                refrac_upd_s[c] = RW'(REFRAC);
                if (SUB_RESET != 0) begin
                    v_upd_s[c] = sat_w(ext(v_nxt_s[c]) - ext(threshold));
                end else begin
                    v_upd_s[c] = {W{1'b0}};
                end
            end else begin
                spk_s[c]        = 1'b0;
                refrac_upd_s[c] = {RW{1'b0}};
                v_upd_s[c]      = v_nxt_s[c];
            end
        end
    end

    // Neuron state and result register; clear beats any accept, stall freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r       <= '0;
            refrac_r  <= '0;
            out_valid <= 1'b0;
            spk_out   <= {N_CH{1'b0}};
            v_out     <= {(N_CH*W){1'b0}};
        end else if (clear) begin
            v_r       <= '0;
            refrac_r  <= '0;
            out_valid <= 1'b0;
            spk_out   <= {N_CH{1'b0}};
            v_out     <= {(N_CH*W){1'b0}};
        end else if (accept_s) begin
            v_r       <= v_upd_s;
            refrac_r  <= refrac_upd_s;
            out_valid <= 1'b1;
            spk_out   <= spk_s;
            v_out     <= v_upd_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_lif_spike_array.sv
// Directed bench for lif_spike_array: default instance plus a subtractive-reset instance
// sharing the same stimulus.
module tb_lif_spike_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] cur_in = 32'h0;
    logic [7:0]  threshold = 8'd20;

    logic        in_ready, out_valid;
    logic [3:0]  spk_out;
    logic [31:0] v_out;
    logic        in_ready_sub, out_valid_sub;
    logic [3:0]  spk_out_sub;
    logic [31:0] v_out_sub;

    int checks = 0;
    int failures = 0;

    logic [31:0] t2_v [6] = '{32'h00ff000a, 32'h00ff0013, 32'h00ff0000,
                              32'h00ff0000, 32'h00ff0000, 32'h00ff000a};
    logic [3:0]  t2_s [6] = '{4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000};

    lif_spike_array dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .cur_in(cur_in), .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
        .spk_out(spk_out), .v_out(v_out)
    );

    lif_spike_array #(.SUB_RESET(1)) u_sub (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_sub),
        .cur_in(cur_in), .threshold(threshold), .out_valid(out_valid_sub), .out_ready(out_ready),
        .spk_out(spk_out_sub), .v_out(v_out_sub)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_spk", {28'b0, spk_out}, 32'h0);
        chk("rst_v", v_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Back-to-back integration, refractory, equality fire, negative leak rounding
        cyc();
        threshold = 8'd20;
        cur_in    = 32'h00ff140a;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("t2_v%0d", i), v_out, t2_v[i]);
            chk($sformatf("t2_spk%0d", i), {28'b0, spk_out}, {28'b0, t2_s[i]});
            chk($sformatf("t2_ov%0d", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("t2_ir%0d", i), {31'b0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        cyc();
        chk("t2_ov_drop", {31'b0, out_valid}, 32'h0);

        // Clear beats a same-cycle accept
        clear    = 1'b1;
        in_valid = 1'b1;
        cur_in   = 32'h05050505;
        cyc();
        clear = 1'b0;
        chk("clr_ov", {31'b0, out_valid}, 32'h0);
        chk("clr_ir", {31'b0, in_ready}, 32'h1);

        // Equality fires, below-threshold leaks, non-positive threshold
        cur_in = 32'h00001413;
        cyc();
        chk("eq_v", v_out, 32'h00000013);
        chk("eq_spk", {28'b0, spk_out}, 32'h2);
        cur_in = 32'h0;
        cyc();
        chk("leak_v", v_out, 32'h00000011);
        chk("leak_spk", {28'b0, spk_out}, 32'h0);
        threshold = 8'd0;
        cyc();
        chk("thr0_v", v_out, 32'h0);
        chk("thr0_spk", {28'b0, spk_out}, 32'hd);
        in_valid = 1'b0;

        // Saturation in both directions
        clear = 1'b1;
        cyc();
        clear     = 1'b0;
        threshold = 8'h7f;
        in_valid  = 1'b1;
        cur_in    = 32'h007f8064;
        cyc();
        chk("sat1_v", v_out, 32'h00008064);
        chk("sat1_spk", {28'b0, spk_out}, 32'h4);
        cur_in = 32'h0000807f;
        cyc();
        chk("sat2_v", v_out, 32'h00008000);
        chk("sat2_spk", {28'b0, spk_out}, 32'h1);
        cyc();
        chk("sat3_v", v_out, 32'h00008000);
        chk("sat3_spk", {28'b0, spk_out}, 32'h0);

        // Backpressure freezes outputs and state
        out_ready = 1'b0;
        threshold = 8'd20;
        cur_in    = 32'h01010101;
        #1;
        chk("bp_ir0", {31'b0, in_ready}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("bp_ir%0d", i + 1), {31'b0, in_ready}, 32'h0);
            chk($sformatf("bp_ov%0d", i + 1), {31'b0, out_valid}, 32'h1);
            chk($sformatf("bp_v%0d", i + 1), v_out, 32'h00008000);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_rel_v", v_out, 32'h01019100);
        chk("bp_rel_spk", {28'b0, spk_out}, 32'h0);
        in_valid = 1'b0;
        cyc();
        chk("bp_ov_drop", {31'b0, out_valid}, 32'h0);

        // Subtractive reset, then clear during refractory
        clear = 1'b1;
        cyc();
        clear    = 1'b0;
        cur_in   = 32'h0000000a;
        in_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("sub_v", v_out_sub, 32'h00000007);
        chk("sub_spk", {28'b0, spk_out_sub}, 32'h1);
        chk("zero_v", v_out, 32'h0);
        chk("zero_spk", {28'b0, spk_out}, 32'h1);
        in_valid = 1'b0;
        clear    = 1'b1;
        cyc();
        clear = 1'b0;
        chk("sub_clr_ov", {31'b0, out_valid_sub}, 32'h0);
        in_valid = 1'b1;
        cyc();
        chk("sub_after_clr_v", v_out_sub, 32'h0000000a);
        chk("sub_after_clr_spk", {28'b0, spk_out_sub}, 32'h0);
        in_valid = 1'b0;

        // Asynchronous reset mid-run, no clock edge needed
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", {31'b0, out_valid}, 32'h0);
        chk("arst_v", v_out, 32'h0);
        chk("arst_spk", {28'b0, spk_out}, 32'h0);
        chk("arst_sub_v", v_out_sub, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_ir", {31'b0, in_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
